// File: rtl/layer1_pkg.sv
// Shared types and defaults for the Layer-1 column drain.
// Lane count, word width, drain FSM states and lane index type.
package layer1_pkg;

  localparam int LANES_DEF = 10;
  localparam int DW_DEF    = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    SETTLE,
    DRAIN
  } drain_state_t;

  typedef logic [$clog2(LANES_DEF)-1:0] lane_t;

endpackage

// File: rtl/layer1_lane_mux.sv
// Selects one lane word out of the captured column register.
// Macro LAYER1_DRAIN_RELU_EN clamps negative words to zero.
module layer1_lane_mux
  import layer1_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic [LANES*DW-1:0]      hold,
  input  logic [$clog2(LANES)-1:0] lane,
  output logic [DW-1:0]            word
);

  logic [DW-1:0] raw;

  // pick the addressed lane out of the flat holding register
  always_comb begin
    raw = hold[int'(lane)*DW +: DW];
  end

  // optional ReLU on the selected word, purely combinational
  always_comb begin
`ifdef LAYER1_DRAIN_RELU_EN
    word = raw[DW-1] ? '0 : raw;
`else
    word = raw;
`endif
  end

endmodule

// File: rtl/layer1_column_drain.sv
// Layer-1 MAC column controller: clear, count taps, settle, drain.
// Build option LAYER1_DRAIN_RELU_EN enables ReLU on out_data.
module layer1_column_drain
  import layer1_pkg::*;
#(
  parameter int LANES   = LANES_DEF,
  parameter int DW      = DW_DEF,
  parameter int TAPS    = 25,
  parameter int MAC_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     tap_valid,
  input  logic [LANES*DW-1:0]      column,
  output logic                     acc_clear,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(LANES)-1:0] out_lane,
  output logic                     out_last,
  output logic                     done
);

  localparam int LW = $clog2(LANES);
  localparam int TW = $clog2(TAPS + 1);
  localparam int SW = $clog2(MAC_LAT + 1);

  localparam logic [TW-1:0] TAP_LAST  = TW'(TAPS - 1);
  localparam logic [SW-1:0] SET_LAST  = SW'(MAC_LAT - 1);
  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);

  drain_state_t state, nxt;

  logic [TW-1:0]       tap_cnt, tap_nxt;
  logic [SW-1:0]       settle_cnt, settle_nxt;
  logic [LW-1:0]       lane, lane_nxt;
  logic [LANES*DW-1:0] hold;
  logic                capture;
  logic                done_nxt;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  // next state, counter updates and capture strobe
  always_comb begin
    nxt        = state;
    tap_nxt    = tap_cnt;
    settle_nxt = settle_cnt;
    lane_nxt   = lane;
    capture    = 1'b0;
    done_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        tap_nxt    = '0;
        settle_nxt = '0;
        lane_nxt   = '0;
        if (start) nxt = CLEAR;
      end
      CLEAR: begin
        tap_nxt    = tap_valid ? TW'(1) : '0;
        settle_nxt = '0;
        if (tap_valid && (TAPS == 1)) nxt = SETTLE;
        else                          nxt = ACCUM;
      end
      ACCUM: begin
        if (tap_valid) begin
          tap_nxt = tap_cnt + TW'(1);
          if (tap_cnt == TAP_LAST) begin
            nxt        = SETTLE;
            settle_nxt = '0;
          end
        end
      end
      SETTLE: begin
        if (settle_cnt == SET_LAST) begin
          capture  = 1'b1;
          nxt      = DRAIN;
          lane_nxt = '0;
        end else begin
          settle_nxt = settle_cnt + SW'(1);
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (lane == LANE_LAST) begin
            nxt      = IDLE;
            done_nxt = 1'b1;
            lane_nxt = '0;
          end else begin
            lane_nxt = lane + LW'(1);
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // tap, settle and lane counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap_cnt    <= '0;
      settle_cnt <= '0;
      lane       <= '0;
    end else begin
      tap_cnt    <= tap_nxt;
      settle_cnt <= settle_nxt;
      lane       <= lane_nxt;
    end
  end

  // column snapshot taken once the array output has settled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       hold <= '0;
    else if (capture) hold <= column;
  end

  // registered control outputs derived from the upcoming state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_clear <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      acc_clear <= (nxt == CLEAR);
      busy      <= (nxt != IDLE);
      out_valid <= (nxt == DRAIN);
      out_last  <= (nxt == DRAIN) && (lane_nxt == LANE_LAST);
      done      <= done_nxt;
    end
  end

  assign out_lane = lane;

  layer1_lane_mux #(
    .LANES(LANES),
    .DW   (DW)
  ) u_mux (
    .hold(hold),
    .lane(lane),
    .word(out_data)
  );

endmodule

// File: tb/tb_layer1_column_drain.sv
// Scoreboard bench for layer1_column_drain with TAPS=3, MAC_LAT=1.
// Expected lane words are queued at window launch and popped by a monitor.
module tb_layer1_column_drain;
  import layer1_pkg::*;

  localparam int LANES   = 10;
  localparam int DW      = 16;
  localparam int TAPS    = 3;
  localparam int MAC_LAT = 1;

  logic                clk;
  logic                reset;
  logic                start;
  logic                tap_valid;
  logic [LANES*DW-1:0] column;
  logic                acc_clear;
  logic                busy;
  logic                out_valid;
  logic                out_ready;
  logic [DW-1:0]       out_data;
  lane_t               out_lane;
  logic                out_last;
  logic                done;

  typedef struct {
    logic [DW-1:0] data;
    lane_t         lane;
    logic          last;
  } exp_t;

  exp_t sb[$];
  exp_t front;
  int   checks;
  int   errs;
  int   dones;
  int   exp_dones;

  layer1_column_drain #(
    .LANES  (LANES),
    .DW     (DW),
    .TAPS   (TAPS),
    .MAC_LAT(MAC_LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .tap_valid(tap_valid),
    .column   (column),
    .acc_clear(acc_clear),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_lane (out_lane),
    .out_last (out_last),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: a negative word reads as zero when ReLU is built in
  function automatic logic [DW-1:0] ref_word(input logic [DW-1:0] v);
`ifdef LAYER1_DRAIN_RELU_EN
    if ($signed(v) < 0) return 16'h0000;
`endif
    return v;
  endfunction

  // monitor: compare presented word against queue head, pop on handshake
  always @(negedge clk) begin
    if (reset) begin
      if (done) dones++;
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_word: got %h lane %0d expected none",
                   out_data, out_lane);
        end else begin
          front = sb[0];
          chk("out_data", 32'(out_data), 32'(front.data));
          chk("out_lane", 32'(out_lane), 32'(front.lane));
          chk("out_last", 32'(out_last), 32'(front.last));
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LANES*DW-1:0] rand_col();
    logic [LANES*DW-1:0] c;
    for (int i = 0; i < LANES; i++) c[i*DW +: DW] = 16'($urandom);
    return c;
  endfunction

  // gap_max < 0 selects the fixed tap pattern 1,0,0,1,0,1
  task automatic run_window(input logic [LANES*DW-1:0] col,
                            input int gap_max, input int ready_pct,
                            input bit bp4, input bit abort6,
                            input bit spam);
    int  n;
    int  ticks;
    int  stall;
    int  g;
    bit  first;
    exp_t e;
    column = col;
    for (int i = 0; i < LANES; i++) begin
      e.data = ref_word(col[i*DW +: DW]);
      e.lane = lane_t'(i);
      e.last = (i == LANES - 1);
      sb.push_back(e);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks = 1;
    chk("acc_clear_on", 32'(acc_clear), 32'd1);
    chk("busy_on", 32'(busy), 32'd1);
    first = 1'b1;
    for (int k = 0; k < TAPS; k++) begin
      if (gap_max < 0) g = (k == 1) ? 2 : ((k == 2) ? 1 : 0);
      else if (gap_max > 0) g = $urandom_range(gap_max, 0);
      else g = 0;
      for (int j = 0; j <= g; j++) begin
        tap_valid = (j == g);
        start = spam ? 1'($urandom_range(1, 0)) : 1'b0;
        tick();
        ticks++;
        if (first) chk("acc_clear_pulse", 32'(acc_clear), 32'd0);
        first = 1'b0;
      end
      if (k < TAPS - 1) chk("no_early_valid", 32'(out_valid), 32'd0);
    end
    tap_valid = 1'($urandom_range(1, 0));
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
      ticks++;
    end
    chk("settle_latency", 32'(n), 32'(MAC_LAT));
    if (gap_max == 0)
      chk("window_latency", 32'(ticks), 32'(1 + TAPS - 1 + MAC_LAT + 1));
    tap_valid = 1'b0;
    column = {LANES{16'hAAAA}};
    if (!abort6) exp_dones++;
    n = 0;
    stall = 0;
    while (n < 200) begin
      if (abort6 && out_valid && out_lane == lane_t'(6)) begin
        reset = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        sb.delete();
        start = 1'b0;
        out_ready = 1'b0;
        tick();
        reset = 1'b1;
        return;
      end
      if (bp4 && out_lane == lane_t'(4) && stall < 5) begin
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = ($urandom_range(99, 0) < ready_pct);
      end
      start = spam ? 1'($urandom_range(1, 0)) : 1'b0;
      tick();
      n++;
      if (done) break;
    end
    start = 1'b0;
    out_ready = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    if (ready_pct == 100)
      chk("drain_cycles", 32'(n), 32'(bp4 ? LANES + 5 : LANES));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [LANES*DW-1:0] c;
    checks = 0;
    errs = 0;
    dones = 0;
    exp_dones = 0;
    reset = 1'b0;
    start = 1'b0;
    tap_valid = 1'b0;
    out_ready = 1'b0;
    column = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();
    start = 1'b1;
    reset = 1'b0;
    #1;
    chk("rst_acc_clear", 32'(acc_clear), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_lane", 32'(out_lane), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    tick();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) begin
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_valid", 32'(out_valid), 32'd0);
    end

    for (int i = 0; i < LANES; i++) c[i*DW +: DW] = 16'(3 * i);
    run_window(c, 0, 100, 1'b0, 1'b0, 1'b0);
    run_window(rand_col(), -1, 100, 1'b0, 1'b0, 1'b0);
    run_window(rand_col(), 0, 100, 1'b1, 1'b0, 1'b0);
    run_window(rand_col(), 2, 60, 1'b0, 1'b0, 1'b1);
    run_window(rand_col(), 0, 100, 1'b0, 1'b1, 1'b1);
    run_window(rand_col(), 0, 100, 1'b0, 1'b0, 1'b0);
    c = rand_col();
    c[2*DW +: DW] = 16'hFFF0;
    c[3*DW +: DW] = 16'h0010;
    run_window(c, 0, 100, 1'b0, 1'b0, 1'b0);
    for (int w = 0; w < 25; w++)
      run_window(rand_col(), 3, 70, 1'b0, 1'b0,
                 1'($urandom_range(1, 0)));

    repeat (3) tick();
    chk("done_count", 32'(dones), 32'(exp_dones));
    chk("sb_final", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

endmodule
